nios2_oci_dct_capture: RTL and testbench

Parametrised successor to the OCI test-bench monitor. It captures data-capture-trace (DCT) words from the Nios II OCI into an internal buffer between arm and test end. It then drains them oldest-first over a valid/ready read port and asserts test_has_ended when the drain is complete. It sits beside the OCI block in the simulation and debug fabric and feeds a trace dumper or JTAG readout.

---
 rtl/nios2_oci_trace_pkg.sv | 30 +++
 rtl/nios2_oci_trace_ram.sv | 25 ++
 rtl/nios2_oci_dct_capture.sv | 161 ++++++++++++++++
 tb/tb_nios2_oci_dct_capture.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and width helpers for the OCI DCT capture buffer.
// Entry width grows by TS_WIDTH when TRACE_TIMESTAMP_EN is defined.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int entry_w(input int cnt_w, input int dct_w, input int ts_w);
    return cnt_w + dct_w + (TS_EN ? ts_w : 0);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// DEPTH x ENTRY_W register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module nios2_oci_trace_ram
  import nios2_oci_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 34
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0]        wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
  output logic [ENTRY_W-1:0]        rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// Captures OCI DCT words between arm and test_ending, then drains them oldest-first.
// Optional per-entry timestamps are enabled with the TRACE_TIMESTAMP_EN macro.
module nios2_oci_dct_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int DCT_WIDTH = 30,
  parameter int CNT_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 1,
  parameter int TS_WIDTH  = 16
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             arm,
  input  logic                                             dct_valid,
  input  logic [DCT_WIDTH-1:0]                             dct_buffer,
  input  logic [CNT_WIDTH-1:0]                             dct_count,
  input  logic                                             test_ending,
  output logic [entry_w(CNT_WIDTH, DCT_WIDTH, TS_WIDTH)-1:0] rd_data,
  output logic                                             rd_valid,
  input  logic                                             rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]                       level,
  output logic                                             overflow,
  output logic                                             test_has_ended,
  output logic [1:0]                                       state
);

  localparam int ENTRY_W = entry_w(CNT_WIDTH, DCT_WIDTH, TS_WIDTH);
  localparam int PTR_W   = ptr_w(DEPTH);
  localparam int LVL_W   = lvl_w(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d, ended_q, ended_d;
  logic               wr_req, full, we;
  logic [ENTRY_W-1:0] wdata;

  assign wr_req = dct_valid && (dct_count != '0);
  assign full   = (level_q == FULL_LVL);

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                arm_acc;

  assign arm_acc = arm && ((state_q == IDLE) || (state_q == DONE));
  assign ts_d    = arm_acc ? '0 : ts_q + TS_WIDTH'(1);
  assign wdata   = {ts_q, dct_count, dct_buffer};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end
`else
  assign wdata = {dct_count, dct_buffer};
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    ended_d  = ended_q;
    we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
          ovf_d    = 1'b0;
          ended_d  = 1'b0;
        end else if (test_ending) begin
          state_d  = DONE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
          ended_d  = 1'b1;
        end
      end
      CAPTURE: begin
        // When full, wrap mode evicts the oldest entry by moving both pointers.
        if (wr_req) begin
          if (!full) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            level_d  = level_q + LVL_W'(1);
          end else begin
            ovf_d = 1'b1;
            if (WRAP_MODE != 0) begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
          end
        end
        if (test_ending) state_d = DRAIN;
      end
      DRAIN: begin
        if (level_q == '0) begin
          state_d = DONE;
          ended_d = 1'b1;
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          level_d  = level_q - LVL_W'(1);
        end
      end
      DONE: begin
        if (arm) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
          ovf_d    = 1'b0;
          ended_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      ended_q  <= ended_d;
    end
  end

  nios2_oci_trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid       = (state_q == DRAIN) && (level_q != '0);
  assign level          = level_q;
  assign overflow       = ovf_q;
  assign test_has_ended = ended_q;
  assign state          = state_q;

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Scoreboard bench: two DEPTH=4 instances (wrap and drop) driven by the same stimulus.
module tb_nios2_oci_dct_capture;
  import nios2_oci_trace_pkg::*;

  localparam int DW  = 30;
  localparam int CW  = 4;
  localparam int TW  = 16;
  localparam int DEP = 4;
  localparam int EW  = entry_w(CW, DW, TW);
  localparam int LW  = CW + DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          dct_valid = 1'b0;
  logic [DW-1:0] dct_buffer = '0;
  logic [CW-1:0] dct_count = '0;
  logic          test_ending = 1'b0;
  logic          rd_ready = 1'b0;

  logic [EW-1:0] rd_data_w, rd_data_d;
  logic          rv_w, rv_d, ovf_w, ovf_d, end_w, end_d;
  logic [2:0]    level_w, level_d;
  logic [1:0]    state_w, state_d;

  logic [LW-1:0] exp_w[$], exp_d[$];
  logic [EW-1:0] got_w[$];
  logic          movf_w, movf_d;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_capture #(.DCT_WIDTH(DW), .CNT_WIDTH(CW), .DEPTH(DEP), .WRAP_MODE(1), .TS_WIDTH(TW)) dut_w (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .rd_data(rd_data_w), .rd_valid(rv_w),
    .rd_ready(rd_ready), .level(level_w), .overflow(ovf_w), .test_has_ended(end_w), .state(state_w));

  nios2_oci_dct_capture #(.DCT_WIDTH(DW), .CNT_WIDTH(CW), .DEPTH(DEP), .WRAP_MODE(0), .TS_WIDTH(TW)) dut_d (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .rd_data(rd_data_d), .rd_valid(rv_d),
    .rd_ready(rd_ready), .level(level_d), .overflow(ovf_d), .test_has_ended(end_d), .state(state_d));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_w.delete();
    exp_d.delete();
    movf_w = 1'b0;
    movf_d = 1'b0;
  endtask

  task automatic model_write(input logic [CW-1:0] cnt, input logic [DW-1:0] data);
    if (cnt == '0) return;
    if (exp_w.size() < DEP) exp_w.push_back({cnt, data});
    else begin
      void'(exp_w.pop_front());
      exp_w.push_back({cnt, data});
      movf_w = 1'b1;
    end
    if (exp_d.size() < DEP) exp_d.push_back({cnt, data});
    else movf_d = 1'b1;
  endtask

  task automatic write_word(input logic [CW-1:0] cnt, input logic [DW-1:0] data, input bit ending);
    dct_valid   = 1'b1;
    dct_count   = cnt;
    dct_buffer  = data;
    test_ending = ending;
    model_write(cnt, data);
    tick();
    dct_valid   = 1'b0;
    test_ending = 1'b0;
  endtask

  task automatic end_pulse();
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      check_eq("rv_w", rv_w, (state_w == 2'd2) && (exp_w.size() != 0));
      if (rv_w && exp_w.size() != 0) begin
        check_eq("lvl_w", level_w, exp_w.size());
        got_w.push_back(rd_data_w);
        check_eq("data_w", rd_data_w[LW-1:0], exp_w.pop_front());
      end
      if (rv_d) begin
        if (exp_d.size() == 0) check_eq("extra_d", rv_d, 1'b0);
        else begin
          check_eq("lvl_d", level_d, exp_d.size());
          check_eq("data_d", rd_data_d[LW-1:0], exp_d.pop_front());
        end
      end
      if (state_w == 2'd2) check_eq("ended_early", end_w, 1'b0);
      if (state_w == 2'd3 && state_d == 2'd3) done = 1'b1;
      else tick();
    end
    if (!done) check_eq("drain_timeout", state_w, 2'd3);
    check_eq("left_w", exp_w.size(), 0);
    check_eq("left_d", exp_d.size(), 0);
    check_eq("ended_w", end_w, 1'b1);
    check_eq("ended_d", end_d, 1'b1);
    check_eq("rv_done", rv_w, 1'b0);
    check_eq("ovf_w", ovf_w, movf_w);
    check_eq("ovf_d", ovf_d, movf_d);
    rd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] hold;
    movf_w = 1'b0;
    movf_d = 1'b0;
    tick();
    tick();
    check_eq("rst_state", state_w, 2'd0);
    check_eq("rst_level", level_w, 3'd0);
    check_eq("rst_rv", rv_w, 1'b0);
    check_eq("rst_ovf", ovf_w, 1'b0);
    check_eq("rst_ended", end_w, 1'b0);
    reset_n = 1'b1;
    tick();

    // IDLE ignores dct_valid; test_ending goes straight to DONE
    dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'h77;
    tick();
    dct_valid = 1'b0;
    check_eq("idle_ignore", level_w, 3'd0);
    end_pulse();
    check_eq("idle_end_state", state_w, 2'd3);
    check_eq("idle_end_ended", end_w, 1'b1);

    // basic capture
    arm_pulse();
    check_eq("arm_state", state_w, 2'd1);
    check_eq("arm_ended", end_w, 1'b0);
    for (int i = 1; i <= 3; i++) write_word(4'd1, DW'(i), 1'b0);
    check_eq("basic_level", level_w, 3'd3);
    end_pulse();
    check_eq("drain_state", state_w, 2'd2);
    drain();

    // empty-word filter
    arm_pulse();
    write_word(4'd2, 30'h0AAAAAAA, 1'b0);
    write_word(4'd0, 30'h0BBBBBBB, 1'b0);
    write_word(4'd5, 30'h0CCCCCCC, 1'b0);
    check_eq("filter_level", level_w, 3'd2);
    end_pulse();
    drain();

    // overflow: wrap keeps W3..W6, drop keeps W1..W4
    arm_pulse();
    for (int i = 1; i <= 6; i++) write_word(4'd1, DW'(32'h100 + i), 1'b0);
    check_eq("ovf_level_w", level_w, 3'd4);
    check_eq("ovf_level_d", level_d, 3'd4);
    check_eq("ovf_flag_w", ovf_w, 1'b1);
    check_eq("ovf_flag_d", ovf_d, 1'b1);
    end_pulse();
    drain();

    // write coinciding with test_ending is captured and drained last
    arm_pulse();
    write_word(4'd1, 30'h201, 1'b0);
    write_word(4'd1, 30'h202, 1'b1);
    check_eq("simul_state", state_w, 2'd2);
    drain();

    // backpressure then asynchronous reset mid-drain
    arm_pulse();
    for (int i = 1; i <= 4; i++) write_word(4'd3, DW'(32'h500 + i), 1'b0);
    end_pulse();
    rd_ready = 1'b1;
    check_eq("bp_rv", rv_w, 1'b1);
    check_eq("bp_first", rd_data_w[LW-1:0], exp_w.pop_front());
    void'(exp_d.pop_front());
    tick();
    rd_ready = 1'b0;
    hold = rd_data_w;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_rv", rv_w, 1'b1);
      check_eq("bp_hold_data", rd_data_w, hold);
      check_eq("bp_hold_lvl", level_w, 3'd3);
      tick();
    end
    check_eq("bp_next", rd_data_w[LW-1:0], exp_w[0]);
    reset_n = 1'b0;
    #1;
    check_eq("arst_state", state_w, 2'd0);
    check_eq("arst_rv", rv_w, 1'b0);
    check_eq("arst_level", level_w, 3'd0);
    check_eq("arst_ended", end_w, 1'b0);
    check_eq("arst_state_d", state_d, 2'd0);
    tick();
    reset_n = 1'b1;
    exp_w.delete();
    exp_d.delete();
    tick();

`ifdef TRACE_TIMESTAMP_EN
    // writes five cycles apart carry timestamps five apart
    arm_pulse();
    tick();
    write_word(4'd1, 30'h301, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    write_word(4'd1, 30'h302, 1'b0);
    end_pulse();
    got_w.delete();
    drain();
    if (got_w.size() == 2)
      check_eq("ts_delta", TW'(got_w[1][EW-1 -: TW] - got_w[0][EW-1 -: TW]), 16'd5);
    else
      check_eq("ts_count", got_w.size(), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
